// File: rtl/regfile_writeback_queue.sv
// Write-back queue feeding the two-write-port register file; one result issued per cycle.
// Define WB_BYPASS_EN to let a result accepted into an empty, unheld queue issue at the accept edge.
module regfile_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dst1,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              in_dual,
  input  logic [ADDR_W-1:0] in_dst2,
  input  logic [DATA_W-1:0] in_data2,
  input  logic              wb_hold,
  output logic              RegWrite,
  output logic              WriteOP2,
  output logic [ADDR_W-1:0] WriteReg1,
  output logic [ADDR_W-1:0] WriteReg2,
  output logic [DATA_W-1:0] WriteData1,
  output logic [DATA_W-1:0] WriteData2,
  output logic [15:0]       pending_mask,
  output logic [ADDR_W-1:0] fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] q_dst1  [DEPTH];
  logic [ADDR_W-1:0] q_dst2  [DEPTH];
  logic [DATA_W-1:0] q_data1 [DEPTH];
  logic [DATA_W-1:0] q_data2 [DEPTH];
  logic [DEPTH-1:0]  q_dual;
  logic [DEPTH-1:0]  q_vld;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] count;

  logic              n_dual;
  logic [DATA_W-1:0] n_data1;
  logic              accept, pop, push, bypass;

  // Same-address dual write collapses to one write carrying the port-2 data
  assign n_dual  = in_dual && (in_dst2 != in_dst1);
  assign n_data1 = (in_dual && (in_dst2 == in_dst1)) ? in_data2 : in_data1;

  assign in_ready   = (count != ADDR_W'(DEPTH));
  assign fifo_count = count;
  assign accept     = in_valid && in_ready;
  assign pop        = !wb_hold && (count != '0);
`ifdef WB_BYPASS_EN
  assign bypass     = accept && !wb_hold && (count == '0);
`else
  assign bypass     = 1'b0;
`endif
  assign push       = accept && !bypass;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_vld      <= '0;
      q_dual     <= '0;
      RegWrite   <= 1'b0;
      WriteOP2   <= 1'b0;
      WriteReg1  <= '0;
      WriteReg2  <= '0;
      WriteData1 <= '0;
      WriteData2 <= '0;
    end else begin
      if (push) begin
        q_dst1[wr_ptr]  <= in_dst1;
        q_dst2[wr_ptr]  <= in_dst2;
        q_data1[wr_ptr] <= n_data1;
        q_data2[wr_ptr] <= in_data2;
        q_dual[wr_ptr]  <= n_dual;
        q_vld[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        RegWrite   <= 1'b1;
        WriteOP2   <= q_dual[rd_ptr];
        WriteReg1  <= q_dst1[rd_ptr];
        WriteReg2  <= q_dst2[rd_ptr];
        WriteData1 <= q_data1[rd_ptr];
        WriteData2 <= q_data2[rd_ptr];
      end else if (bypass) begin
        RegWrite   <= 1'b1;
        WriteOP2   <= n_dual;
        WriteReg1  <= in_dst1;
        WriteReg2  <= in_dst2;
        WriteData1 <= n_data1;
        WriteData2 <= in_data2;
      end else begin
        RegWrite <= 1'b0;
        WriteOP2 <= 1'b0;
      end
    end
  end

  // Queued writes plus whatever is on the write ports this cycle
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) begin
        pending_mask[q_dst1[i]] = 1'b1;
        if (q_dual[i]) pending_mask[q_dst2[i]] = 1'b1;
      end
    end
    if (RegWrite) pending_mask[WriteReg1] = 1'b1;
    if (WriteOP2) pending_mask[WriteReg2] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: directed pushes queue expected writes, a monitor checks each issue.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dst1 = '0, in_dst2 = '0;
  logic [15:0] in_data1 = '0, in_data2 = '0;
  logic        in_dual = 1'b0;
  logic        wb_hold = 1'b0;
  logic        RegWrite, WriteOP2;
  logic [3:0]  WriteReg1, WriteReg2;
  logic [15:0] WriteData1, WriteData2;
  logic [15:0] pending_mask;
  logic [3:0]  fifo_count;

`ifdef WB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [3:0]  r1;
    logic [15:0] d1;
    logic        op2;
    logic [3:0]  r2;
    logic [15:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   iss_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   c0 = 0;

  regfile_writeback_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dst1(in_dst1), .in_data1(in_data1), .in_dual(in_dual),
    .in_dst2(in_dst2), .in_data2(in_data2),
    .wb_hold(wb_hold),
    .RegWrite(RegWrite), .WriteOP2(WriteOP2),
    .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      iss_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue got reg=%0d data=%0h want none", WriteReg1, WriteData1);
      end else begin
        e = exp_q.pop_front();
        chk("wreg1", 32'(WriteReg1), 32'(e.r1));
        chk("wdata1", 32'(WriteData1), 32'(e.d1));
        chk("wop2", 32'(WriteOP2), 32'(e.op2));
        if (e.op2) begin
          chk("wreg2", 32'(WriteReg2), 32'(e.r2));
          chk("wdata2", 32'(WriteData2), 32'(e.d2));
        end
      end
    end else begin
      chk("op2_idle", 32'(WriteOP2), 32'd0);
    end
  end

  task automatic send(input logic [3:0] d1, input logic [15:0] x1, input logic du,
                      input logic [3:0] d2, input logic [15:0] x2,
                      input logic [3:0] er1, input logic [15:0] ed1, input logic eop2,
                      input logic [3:0] er2, input logic [15:0] ed2);
    exp_t ex;
    bit got = 0;
    ex.r1 = er1; ex.d1 = ed1; ex.op2 = eop2; ex.r2 = er2; ex.d2 = ed2;
    in_dst1 = d1; in_data1 = x1; in_dual = du; in_dst2 = d2; in_data2 = x2;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(ex);
        @(posedge clk); #1;
        acc_cyc = cyc;
        got = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout got ready=0 want ready=1 dst1=%0d", d1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two edges with a result offered
    in_valid = 1'b1; in_dst1 = 4'd7; in_data1 = 16'h7777;
    step(2);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_op2", 32'(WriteOP2), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_pending", 32'(pending_mask), 32'd0);
    chk("rst_wreg1", 32'(WriteReg1), 32'd0);
    chk("rst_wdata1", 32'(WriteData1), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    step(1);

    // Single write
    iss_q.delete();
    send(4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0);
    chk("single_pend_acc", 32'(pending_mask), 32'h0008);
`ifndef WB_BYPASS_EN
    step(1);
    chk("single_pend_iss", 32'(pending_mask), 32'h0008);
`endif
    step(1);
    chk("single_pend_clr", 32'(pending_mask), 32'h0000);
    chk("single_pulse", 32'(RegWrite), 32'd0);
    chk("single_nissue", 32'(iss_q.size()), 32'd1);
    if (iss_q.size() > 0) chk("single_latency", 32'(iss_q[0] - acc_cyc), 32'(LAT));

    // Dual write and same-address collapse
    send(4'd15, 16'h1234, 1'b1, 4'd0, 16'h5678, 4'd15, 16'h1234, 1'b1, 4'd0, 16'h5678);
    chk("dual_pend", 32'(pending_mask), 32'h8001);
    step(3);
    send(4'd5, 16'h0001, 1'b1, 4'd5, 16'h0002, 4'd5, 16'h0002, 1'b0, 4'd5, 16'h0002);
    chk("coll_pend", 32'(pending_mask), 32'h0020);
    step(3);

    // Fill under hold, then release with a fifth result waiting
    wb_hold = 1'b1;
    iss_q.delete();
    send(4'd1, 16'h1111, 1'b0, 4'd0, 16'h0, 4'd1, 16'h1111, 1'b0, 4'd0, 16'h0);
    send(4'd2, 16'h2222, 1'b1, 4'd9, 16'h9999, 4'd2, 16'h2222, 1'b1, 4'd9, 16'h9999);
    send(4'd1, 16'h3333, 1'b0, 4'd0, 16'h0, 4'd1, 16'h3333, 1'b0, 4'd0, 16'h0);
    send(4'd12, 16'hCCCC, 1'b1, 4'd12, 16'hDDDD, 4'd12, 16'hDDDD, 1'b0, 4'd12, 16'hDDDD);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_pend", 32'(pending_mask), 32'h1206);
    chk("hold_noissue", 32'(iss_q.size()), 32'd0);
    c0 = cyc;
    fork
      send(4'd6, 16'h6666, 1'b0, 4'd0, 16'h0, 4'd6, 16'h6666, 1'b0, 4'd0, 16'h0);
      wb_hold = 1'b0;
    join
    chk("fifth_accept_cyc", 32'(acc_cyc), 32'(c0 + 2));
    step(8);
    chk("burst_nissue", 32'(iss_q.size()), 32'd5);
    if (iss_q.size() == 5) begin
      chk("burst_first", 32'(iss_q[0]), 32'(c0 + 1));
      chk("burst_span", 32'(iss_q[4] - iss_q[0]), 32'd4);
    end
    chk("burst_empty", 32'(fifo_count), 32'd0);

    // Reset with three writes queued
    wb_hold = 1'b1;
    send(4'd4, 16'h4444, 1'b0, 4'd0, 16'h0, 4'd4, 16'h4444, 1'b0, 4'd0, 16'h0);
    send(4'd8, 16'h8888, 1'b0, 4'd0, 16'h0, 4'd8, 16'h8888, 1'b0, 4'd0, 16'h0);
    send(4'd11, 16'hBBBB, 1'b0, 4'd0, 16'h0, 4'd11, 16'hBBBB, 1'b0, 4'd0, 16'h0);
    chk("mid_count", 32'(fifo_count), 32'd3);
    chk("mid_pend", 32'(pending_mask), 32'h0910);
    rst = 1'b0;
    exp_q.delete();
    iss_q.delete();
    step(1);
    rst = 1'b1;
    wb_hold = 1'b0;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_pend", 32'(pending_mask), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    step(5);
    chk("mid_rst_noissue", 32'(iss_q.size()), 32'd0);

    // Push into an empty queue after reset
    send(4'd10, 16'hAAAA, 1'b0, 4'd0, 16'h0, 4'd10, 16'hAAAA, 1'b0, 4'd0, 16'h0);
    step(3);
    chk("post_nissue", 32'(iss_q.size()), 32'd1);
    if (iss_q.size() > 0) chk("post_latency", 32'(iss_q[0] - acc_cyc), 32'(LAT));
    chk("all_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side driver for the 16x16 two-write-port register file. Sits between the MEM/WB pipeline register and the register file write ports.
- Accepts completed results through a valid/ready handshake; each result carries one or two destination writes.
- Buffers results in a small FIFO and issues at most one result per cycle onto WriteReg1/2, WriteData1/2, RegWrite and WriteOP2.
- Exports a pending-write mask so decode can detect RAW hazards.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register index width (16 registers)
- DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-low reset
- in_valid  in  1  result available
- in_ready  out  1  queue can accept
- in_dst1  in  ADDR_W  first destination register
- in_data1  in  DATA_W  first result
- in_dual  in  1  second write present
- in_dst2  in  ADDR_W  second destination register
- in_data2  in  DATA_W  second result
- wb_hold  in  1  suppress issue this cycle
- RegWrite  out  1  write-port-1 enable (registered)
- WriteOP2  out  1  write-port-2 enable (registered)
- WriteReg1  out  ADDR_W  port-1 index (registered)
- WriteReg2  out  ADDR_W  port-2 index (registered)
- WriteData1  out  DATA_W  port-1 data (registered)
- WriteData2  out  DATA_W  port-2 data (registered)
- pending_mask  out  16  bit r set = a write to register r is queued or currently issuing
- fifo_count  out  ADDR_W  occupied entries, 0..DEPTH

Behaviour:
- Reset (rst=0 at a rising edge):
  - FIFO emptied; fifo_count=0.
  - RegWrite=0, WriteOP2=0, WriteReg1/2=0, WriteData1/2=0.
  - Any queued writes are discarded, including mid-burst.
- Accept:
  - in_ready = (fifo_count != DEPTH). This is combinational from state only; there is no same-cycle pop credit.
  - A transfer occurs when in_valid=1 and in_ready=1; the entry is pushed at that edge.
- Entry normalisation at push:
  - If in_dual=1 and in_dst2==in_dst1, store a single write {dst1, data2} with dual=0. Port 2 wins and no same-address double write is ever issued.
  - If in_dual=0, dst2/data2 are stored but ignored.
- Issue, evaluated each edge:
  - If wb_hold=0 and the FIFO was non-empty before the edge, pop the head into the output registers: RegWrite=1, WriteOP2=entry.dual, WriteReg/WriteData from the entry.
  - Otherwise RegWrite=0 and WriteOP2=0; WriteReg/WriteData hold their previous values.
  - Each issue cycle is a single-cycle pulse.
- Simultaneous push and pop in the same edge: fifo_count is unchanged, and pointers wrap modulo DEPTH.
- Pushing into a full FIFO is impossible because in_ready=0. Popping from an empty FIFO never occurs.
- Latency without bypass: accepted at edge N, earliest RegWrite=1 is after edge N+1 (2 cycles). Sustained throughput is 1 result per cycle.
- Ordering: strictly FIFO. Writes to the same register land in acceptance order.
- pending_mask (combinational):
  - OR of one-hot(dst1) over all valid entries, plus one-hot(dst2) for entries with dual=1.
  - Plus one-hot(WriteReg1) when RegWrite=1, and one-hot(WriteReg2) when WriteOP2=1.
- Reset is 0 on all bits.

Optional Feature:
- WB_BYPASS_EN defined:
  - When fifo_count==0 and wb_hold=0, an accepted result goes directly to the output registers at the accept edge, with RegWrite=1 one cycle after acceptance. The FIFO is not written.
  - Normalisation rules still apply.
- Undefined: every result passes through the FIFO, giving a minimum latency of 2 cycles.

Test Plan:
- Reset: hold rst=0 for 2 edges with in_valid=1 -> RegWrite=0, WriteOP2=0, fifo_count=0, pending_mask=0, in_ready=1 after release.
- Single write: push {dst1=3, data1=16'hBEEF, dual=0} -> 2 cycles later one-cycle RegWrite=1, WriteReg1=3, WriteData1=16'hBEEF, WriteOP2=0; pending_mask bit 3 set from accept until after the issue cycle.
- Dual write: push {dst1=15, 16'h1234, dual=1, dst2=0, 16'h5678} -> RegWrite=1, WriteOP2=1, WriteReg1=15, WriteReg2=0, data matches.
- Dual collision: push {dst1=5, 16'h0001, dual=1, dst2=5, 16'h0002} -> WriteReg1=5, WriteData1=16'h0002, WriteOP2=0.
- Full/hold: wb_hold=1, push 5 back-to-back -> first 4 accepted, in_ready=0, fifo_count=4. Release hold -> 4 consecutive RegWrite pulses in order, and a 5th accepted the cycle after the first pop.
- Reset mid-burst: 3 queued, rst=0 for one edge -> fifo_count=0, no further RegWrite pulses. With WB_BYPASS_EN, a push into an empty queue gives RegWrite=1 after 1 cycle.
